// File: rtl/orientation_histogram_if.sv
// orientation_histogram_if: keypoint start, orientation-stage request/response and histogram result signals
interface orientation_histogram_if #(
  parameter int WIDTH = 64,
  parameter int HEIGHT = 64,
  parameter int WINDOW = 4
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(WINDOW * WINDOW + 1);
  logic [XW-1:0] keypoint_x;
  logic [YW-1:0] keypoint_y;
  logic keypoint_valid;
  logic busy;
  logic [XW-1:0] center_addr_x;
  logic [YW-1:0] center_addr_y;
  logic orient_valid_in;
  logic orient_valid_out;
  logic [2:0] bin_in;
  logic [8*CW-1:0] hist_out;
  logic [2:0] dominant_bin;
  logic [CW-1:0] dominant_count;
  logic hist_valid;
  modport slave (
    input keypoint_x, keypoint_y, keypoint_valid, orient_valid_out, bin_in,
    output busy, center_addr_x, center_addr_y, orient_valid_in, hist_out, dominant_bin, dominant_count, hist_valid
  );
  modport master (
    output keypoint_x, keypoint_y, keypoint_valid, orient_valid_out, bin_in,
    input busy, center_addr_x, center_addr_y, orient_valid_in, hist_out, dominant_bin, dominant_count, hist_valid
  );
endinterface

// File: rtl/orientation_histogram.sv
// orientation_histogram: bins orientations of a WINDOWxWINDOW patch around a keypoint and finds the dominant bin
module orientation_histogram #(
  parameter int WIDTH = 64,
  parameter int HEIGHT = 64,
  parameter int WINDOW = 4
) (
  input logic clk_in,
  input logic rst_n_in,
  orientation_histogram_if.slave bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int RW = $clog2(WINDOW);
  localparam int CW = $clog2(WINDOW * WINDOW + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ARGMAX, DONE} state_t;
  state_t state, state_nx;
  logic [XW-1:0] kx, addr_x;
  logic [YW-1:0] ky, addr_y;
  logic [RW-1:0] col, row;
  logic [2:0] idx, best_bin;
  logic [CW-1:0] best_cnt;
  logic [CW-1:0] hist [8];
  logic [XW:0] px;
  logic [YW:0] py;
  logic inb, last_col, last, step;
  assign px = (XW+1)'(kx) - (XW+1)'(WINDOW / 2) + (XW+1)'(col);
  assign py = (YW+1)'(ky) - (YW+1)'(WINDOW / 2) + (YW+1)'(row);
  assign inb = !px[XW] && px < (XW+1)'(WIDTH) && !py[YW] && py < (YW+1)'(HEIGHT);
  assign last_col = col == RW'(WINDOW - 1);
  assign last = last_col && row == RW'(WINDOW - 1);
  assign step = (state == ISSUE && !inb) || (state == WAIT && bus.orient_valid_out);
  assign bus.dominant_bin = best_bin;
  assign bus.dominant_count = best_cnt;
  always_ff @(posedge clk_in) begin
    state <= !rst_n_in ? IDLE : state_nx;
  end
  always_comb begin
    state_nx = state;
    bus.busy = state != IDLE;
    bus.orient_valid_in = state == ISSUE && inb;
    bus.hist_valid = state == DONE;
    bus.center_addr_x = state == ISSUE ? px[XW-1:0] : addr_x;
    bus.center_addr_y = state == ISSUE ? py[YW-1:0] : addr_y;
    case (state)
      IDLE: state_nx = bus.keypoint_valid ? ISSUE : IDLE;
      ISSUE: state_nx = inb ? WAIT : (last ? ARGMAX : ISSUE);
      WAIT: state_nx = bus.orient_valid_out ? (last ? ARGMAX : ISSUE) : WAIT;
      ARGMAX: state_nx = idx == 3'd7 ? DONE : ARGMAX;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.hist_out = '0;
    for (int k = 0; k < 8; k++) bus.hist_out[k*CW +: CW] = hist[k];
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      kx <= '0;
      ky <= '0;
      addr_x <= '0;
      addr_y <= '0;
      col <= '0;
      row <= '0;
      idx <= '0;
      best_bin <= '0;
      best_cnt <= '0;
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else begin
      if (state == IDLE && bus.keypoint_valid) begin
        kx <= bus.keypoint_x;
        ky <= bus.keypoint_y;
        col <= '0;
        row <= '0;
        idx <= '0;
        best_bin <= '0;
        best_cnt <= '0;
        for (int k = 0; k < 8; k++) hist[k] <= '0;
      end
      if (state == ISSUE && inb) begin
        addr_x <= px[XW-1:0];
        addr_y <= py[YW-1:0];
      end
      if (state == WAIT && bus.orient_valid_out) hist[bus.bin_in] <= hist[bus.bin_in] + CW'(1);
      if (step) begin
        col <= last_col ? '0 : col + RW'(1);
        row <= last_col ? (last ? '0 : row + RW'(1)) : row;
      end
      if (state == ARGMAX) begin
        idx <= idx + 3'd1;
        if (hist[idx] > best_cnt) begin
          best_cnt <= hist[idx];
          best_bin <= idx;
        end
      end
    end
  end
endmodule

// File: doc/orientation_histogram.md
# orientation_histogram

Keypoint orientation accumulator sitting directly downstream of the per-pixel gradient orientation stage. For each keypoint it walks a WINDOW×WINDOW patch centred on the keypoint and, for each in-image pixel, issues one center-address request to the orientation stage. It bins each returned 3-bit orientation into an 8-bin histogram, then scans for the dominant bin and presents the histogram and winner to the descriptor/keypoint logic.

## Interface
- WIDTH, 64, image width in pixels
- HEIGHT, 64, image height in pixels
- WINDOW, 4, patch side length; even, ≥2. Derived CW = $clog2(WINDOW*WINDOW+1) = bin counter width.
- clk_in  input  1  single clock, all logic on posedge
- rst_n_in  input  1  reset, synchronous, active-low
- keypoint_x  input  $clog2(WIDTH)  keypoint column, sampled on keypoint_valid
- keypoint_y  input  $clog2(HEIGHT)  keypoint row, sampled on keypoint_valid
- keypoint_valid  input  1  one-cycle start pulse
- busy  output  1  high from the cycle after an accepted start until the cycle hist_valid pulses (inclusive)
- center_addr_x  output  $clog2(WIDTH)  pixel column to the orientation stage
- center_addr_y  output  $clog2(HEIGHT)  pixel row to the orientation stage
- orient_valid_in  output  1  one-cycle request pulse to the orientation stage
- orient_valid_out  input  1  one-cycle response pulse from the orientation stage
- bin_in  input  3  orientation bin, valid with orient_valid_out
- hist_out  output  8*CW  bin k at [k*CW +: CW]
- dominant_bin  output  3  index of the largest bin
- dominant_count  output  CW  count in dominant_bin
- hist_valid  output  1  one-cycle pulse; hist_out/dominant_* are valid and held until the next accepted start

## Operation
- States: IDLE, ISSUE, WAIT, ARGMAX, DONE.
- IDLE: on keypoint_valid, latch keypoint, clear all 8 bins, col=row=0, → ISSUE. keypoint_valid is ignored in every other state.
- Sample coordinate: px = kx − WINDOW/2 + col, py = ky − WINDOW/2 + row. Compute signed, one bit wider than the coordinate.
- Raster order: col fastest, then row.
- ISSUE, in bounds (0≤px<WIDTH, 0≤py<HEIGHT): drive center_addr_x/y = px/py, pulse orient_valid_in, → WAIT.
- ISSUE, out of bounds: no request; advance col/row that cycle. If it was the last sample, → ARGMAX; else stay in ISSUE.
- WAIT: center_addr_x/y held stable until orient_valid_out, because the orientation stage re-samples the center across several cycles. On orient_valid_out, hist[bin_in] += 1 and advance. Last sample → ARGMAX, else → ISSUE.
- Bins cannot overflow: the maximum count is WINDOW², which fits in CW bits.
- ARGMAX: 8 cycles, one bin per cycle in order 0..7. Replace the candidate only on strictly greater, so ties resolve to the lowest index. Then → DONE.
- DONE: pulse hist_valid, drop busy next cycle, → IDLE.
- Keypoint coordinate ≥ WIDTH/HEIGHT: all out-of-bounds samples are skipped; hist all zero, dominant_bin=0, dominant_count=0.
- Reset (any state, incl. mid-WAIT): back to IDLE. A late orient_valid_out arriving after reset is ignored.

## Timing
- Reset values: busy=0, orient_valid_in=0, center_addr_x/y=0, hist_out=0, dominant_bin=0, dominant_count=0, hist_valid=0.
- Start → first orient_valid_in: 2 cycles when sample (0,0) is in bounds (cycle 1 IDLE→ISSUE, cycle 2 pulse).
- Per in-bounds sample: 1 issue cycle + L response latency + 1 cycle; the next request issues the cycle after orient_valid_out.
- Per skipped sample: 1 cycle.
- Last sample done → hist_valid: 9 cycles (8 ARGMAX + DONE).
- Only one request is outstanding at any time; orient_valid_in never pulses while in WAIT.
- hist_out updates visibly during accumulation. Consumers sample only on hist_valid.

## Test plan
- Keypoint (32,32), WINDOW=4, stub returns bin 3 after L=5 → 16 requests covering x,y ∈ 30..33; hist[3]=16, all other bins 0; dominant_bin=3, dominant_count=16; one hist_valid pulse.
- Keypoint (0,0) → only 4 requests, (0,0),(1,0),(0,1),(1,1); 12 skipped samples; bin sum=4.
- Keypoint (63,63) → requests only at x,y ∈ 61..63 (9 requests); no address exceeds 63.
- Stub alternates bins 5,1 over the 16 samples → hist[1]=hist[5]=8; dominant_bin=1 (tie → lowest).
- keypoint_valid pulsed mid-WAIT with different coordinates → ignored; result matches the first keypoint. Random stub latency 1..12 → identical histogram; center_addr constant throughout every WAIT.
- rst_n_in low for 1 cycle mid-WAIT → all outputs return to reset values. A late stub response produces no bin update. The next keypoint yields a correct fresh histogram.
